mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer in front of the 8x8 memory cell array.
//  It latches one request (read or write), drives the array's select/rw/address/data
//  lines, waits for the array's valid, then returns read data and a one-cycle done.
//  It sits between the bus-side masters and the fsm3-controlled memory datapath.
// PARAMETERS
//  ADDR_W   3   word address width (8 words)
//  DATA_W   8   data width
//  TIMEOUT  15  max cycles waiting for mem_valid in ACCESS before abort (>=1)
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req0/req1  in   1       request; held high until matching done
//  op0/op1    in   1       1=write, 0=read
//  addr0/1    in   ADDR_W  word address
//  wdata0/1   in   DATA_W  write data
//  gnt0/gnt1  out  1       grant; high from ACCESS entry through DONE
//  done0/1    out  1       one-cycle completion pulse
//  err        out  1       valid with done: 1 = timeout abort
//  rdata      out  DATA_W  read data; held until next read completes
//  mem_select out  1       array select (drives fsm3 select)
//  mem_rw     out  1       array op, 1=write (drives fsm3 op)
//  mem_addr   out  ADDR_W  array address
//  mem_wdata  out  DATA_W  array write data
//  mem_rdata  in   DATA_W  array read data
//  mem_valid  in   1       array access complete (fsm3 valid)
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, all outputs 0, last=1 (req0 wins first tie),
//   wait counter=0. Reset mid-access aborts with no done; mem_select drops immediately.
//  FSM states: IDLE, ACCESS, DONE. All outputs registered.
//  IDLE: if neither req, stay. Else pick winner: sole requester wins; if both, winner =
//   ~last. Latch winner's op/addr/wdata into mem_rw/mem_addr/mem_wdata, set mem_select=1,
//   gnt_winner=1, wait counter=0 -> ACCESS.
//  ACCESS: mem_* held stable. Each cycle without mem_valid, counter+1.
//   mem_valid=1 -> if read, rdata<=mem_rdata; err<=0; mem_select<=0; done_winner<=1 -> DONE.
//   counter==TIMEOUT-1 and no mem_valid -> err<=1, mem_select<=0, done_winner<=1, rdata
//   unchanged -> DONE. mem_valid on the timeout cycle counts as success.
//  DONE (one cycle): done/err visible; last<=winner; next edge clears done, err, gnt -> IDLE.
//  Latency: req sampled at edge N -> mem_select/gnt high after N; mem_valid sampled at
//   edge M -> done high for cycle after M. Min 3 cycles per access (IDLE/ACCESS/DONE).
//  req or op/addr/wdata changing during ACCESS is ignored (latched copy used).
//  Requester still high in IDLE after its done is re-arbitrated normally; with other
//   requester also high, the other wins (strict alternation under contention).
//  mem_valid outside ACCESS is ignored. gnt0 and gnt1 never high together.
//  Counter width = clog2(TIMEOUT)+1; no wrap possible since abort fires first.
// TESTING
//  1. req0 write addr=3 wdata=8'hA5, mem_valid after 2 cycles -> mem_rw=1, mem_addr=3,
//     mem_wdata=A5 while select; done0 one pulse, err=0, rdata unchanged.
//  2. req1 read addr=5, mem_rdata=8'h3C with mem_valid -> rdata=3C with done1, gnt0=0.
//  3. req0,req1 both held for 4 accesses from reset -> grant order 0,1,0,1; never overlap.
//  4. req0 read, mem_valid held 0 -> done0 and err=1 exactly TIMEOUT cycles after
//     select rise; mem_select low in DONE.
//  5. rst_n low mid-ACCESS -> all outputs 0 same cycle, no done; after release req1 and
//     req0 together -> req0 granted first.
//  6. req0 changes addr 2->7 during ACCESS -> mem_addr stays 2 until done.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 8x8 memory cell array.
// The master modport is the environment (requesters + array); slave is the arbiter.
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              op0;
  logic              op1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_select;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport master (
    output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_valid,
    input  gnt0, gnt1, done0, done1, err, rdata, mem_select, mem_rw, mem_addr, mem_wdata
  );

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_valid,
    output gnt0, gnt1, done0, done1, err, rdata, mem_select, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the memory cell array: latches one
// request, drives the array until mem_valid (or timeout), then pulses done for the winner.
module mem_access_arbiter #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_arbiter_if.slave   bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_r;
  logic              last_r;
  logic              winner_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              pick1_s;
  logic              sel_op_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Arbitration: a sole requester wins; under contention the one not served last wins.
  always_comb begin
    pick1_s     = 1'b0;
    sel_op_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (bus.req0 && bus.req1) begin
      pick1_s = ~last_r;
    end else if (bus.req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if (pick1_s) begin
      sel_op_s    = bus.op1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_op_s    = bus.op0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
  end

  // Sequencer FSM with all outputs registered; last_r resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      last_r         <= 1'b1;
      winner_r       <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      bus.gnt0       <= 1'b0;
      bus.gnt1       <= 1'b0;
      bus.done0      <= 1'b0;
      bus.done1      <= 1'b0;
      bus.err        <= 1'b0;
      bus.rdata      <= {DATA_W{1'b0}};
      bus.mem_select <= 1'b0;
      bus.mem_rw     <= 1'b0;
      bus.mem_addr   <= {ADDR_W{1'b0}};
      bus.mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            winner_r       <= pick1_s;
            bus.mem_rw     <= sel_op_s;
            bus.mem_addr   <= sel_addr_s;
            bus.mem_wdata  <= sel_wdata_s;
            bus.mem_select <= 1'b1;
            bus.gnt0       <= ~pick1_s;
            bus.gnt1       <= pick1_s;
            cnt_r          <= {CNT_W{1'b0}};
            state_r        <= S_ACCESS;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACCESS: begin
          // mem_valid on the last counted cycle still wins over the abort.
          if (bus.mem_valid) begin
            if (!bus.mem_rw) begin
              bus.rdata <= bus.mem_rdata;
            end else begin
              bus.rdata <= bus.rdata;
            end
            bus.err        <= 1'b0;
            bus.mem_select <= 1'b0;
            bus.done0      <= ~winner_r;
            bus.done1      <= winner_r;
            state_r        <= S_DONE;
          end else if (cnt_r == CNT_LAST) begin
            bus.err        <= 1'b1;
            bus.mem_select <= 1'b0;
            bus.done0      <= ~winner_r;
            bus.done1      <= winner_r;
            state_r        <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DONE: begin
          last_r    <= winner_r;
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.err   <= 1'b0;
          bus.gnt0  <= 1'b0;
          bus.gnt1  <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          bus.mem_select <= 1'b0;
          bus.gnt0       <= 1'b0;
          bus.gnt1       <= 1'b0;
          bus.done0      <= 1'b0;
          bus.done1      <= 1'b0;
          bus.err        <= 1'b0;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: drives and samples 1 time unit after each rising edge.
module tb_mem_access_arbiter;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  mem_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [25:0] outs;
  assign outs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.rdata,
                 bus.mem_select, bus.mem_rw, bus.mem_addr, bus.mem_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.addr0 = 3'd0; bus.addr1 = 3'd0; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    bus.mem_rdata = 8'h00; bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    n_cmp++;
    if (outs !== 26'd0) begin
      n_fail++; $display("FAIL reset_outs: got %h want %h", outs, 26'd0);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (outs !== 26'd0) begin
      n_fail++; $display("FAIL idle_outs: got %h want %h", outs, 26'd0);
    end
  endtask

  task automatic test_write();
    bus.req0 = 1'b1; bus.op0 = 1'b1; bus.addr0 = 3'd3; bus.wdata0 = 8'hA5;
    bus.mem_rdata = 8'hFF;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.gnt0, bus.gnt1}
        !== {1'b1, 1'b1, 3'd3, 8'hA5, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wr_issue: got sel=%b rw=%b a=%0d d=%h g0=%b g1=%b",
        bus.mem_select, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.gnt0, bus.gnt1);
    end
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.done0}
        !== {1'b1, 1'b1, 3'd3, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL wr_hold: got sel=%b rw=%b a=%0d d=%h done0=%b",
        bus.mem_select, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.done0);
    end
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.req0 = 1'b0;
    n_cmp++;
    if ({bus.done0, bus.done1, bus.err, bus.rdata, bus.mem_select, bus.gnt0}
        !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL wr_done: got d0=%b d1=%b err=%b rdata=%h sel=%b g0=%b want 1 0 0 00 0 1",
        bus.done0, bus.done1, bus.err, bus.rdata, bus.mem_select, bus.gnt0);
    end
    tick();
    n_cmp++;
    if ({bus.done0, bus.gnt0, bus.err} !== 3'b000) begin
      n_fail++; $display("FAIL wr_pulse: got d0=%b g0=%b err=%b want 000", bus.done0, bus.gnt0, bus.err);
    end
  endtask

  task automatic test_read();
    bus.req1 = 1'b1; bus.op1 = 1'b0; bus.addr1 = 3'd5;
    tick();
    n_cmp++;
    if ({bus.gnt1, bus.gnt0, bus.mem_select, bus.mem_rw, bus.mem_addr}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd5}) begin
      n_fail++; $display("FAIL rd_issue: got g1=%b g0=%b sel=%b rw=%b a=%0d",
        bus.gnt1, bus.gnt0, bus.mem_select, bus.mem_rw, bus.mem_addr);
    end
    bus.mem_rdata = 8'h3C; bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.req1 = 1'b0;
    n_cmp++;
    if ({bus.done1, bus.done0, bus.gnt0, bus.err, bus.rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h3C}) begin
      n_fail++; $display("FAIL rd_done: got d1=%b d0=%b g0=%b err=%b rdata=%h want 1 0 0 0 3c",
        bus.done1, bus.done0, bus.gnt0, bus.err, bus.rdata);
    end
    tick();
    n_cmp++;
    if ({bus.done1, bus.gnt1, bus.rdata} !== {1'b0, 1'b0, 8'h3C}) begin
      n_fail++; $display("FAIL rd_after: got d1=%b g1=%b rdata=%h want 0 0 3c", bus.done1, bus.gnt1, bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_w;
    test_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 3'd1; bus.addr1 = 3'd6;
    for (int i = 0; i < 4; i++) begin
      exp_w = (i % 2) == 1;
      tick();
      n_cmp++;
      if ({bus.gnt1, bus.gnt0, bus.mem_addr} !== (exp_w ? {2'b10, 3'd6} : {2'b01, 3'd1})) begin
        n_fail++; $display("FAIL rr_gnt%0d: got g1g0=%b%b a=%0d want winner %0d",
          i, bus.gnt1, bus.gnt0, bus.mem_addr, exp_w);
      end
      bus.mem_rdata = 8'h10 + 8'(i); bus.mem_valid = 1'b1;
      tick();
      bus.mem_valid = 1'b0;
      n_cmp++;
      if ({bus.done1, bus.done0, bus.gnt1 & bus.gnt0} !== (exp_w ? 3'b100 : 3'b010)) begin
        n_fail++; $display("FAIL rr_done%0d: got d1=%b d0=%b g1=%b g0=%b",
          i, bus.done1, bus.done0, bus.gnt1, bus.gnt0);
      end
      tick();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    n_cmp++;
    if (bus.rdata !== 8'h13) begin
      n_fail++; $display("FAIL rr_rdata: got %h want 13", bus.rdata);
    end
  endtask

  task automatic test_timeout();
    bus.req0 = 1'b1; bus.op0 = 1'b0; bus.addr0 = 3'd4; bus.mem_rdata = 8'h77;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    n_cmp++;
    if ({bus.done0, bus.err, bus.mem_select} !== 3'b001) begin
      n_fail++; $display("FAIL to_early: got d0=%b err=%b sel=%b want 0 0 1", bus.done0, bus.err, bus.mem_select);
    end
    tick();
    bus.req0 = 1'b0;
    n_cmp++;
    if ({bus.done0, bus.err, bus.mem_select, bus.rdata} !== {1'b1, 1'b1, 1'b0, 8'h13}) begin
      n_fail++; $display("FAIL to_done: got d0=%b err=%b sel=%b rdata=%h want 1 1 0 13",
        bus.done0, bus.err, bus.mem_select, bus.rdata);
    end
    tick();
    n_cmp++;
    if ({bus.done0, bus.err, bus.gnt0} !== 3'b000) begin
      n_fail++; $display("FAIL to_clear: got d0=%b err=%b g0=%b want 000", bus.done0, bus.err, bus.gnt0);
    end
  endtask

  task automatic test_reset_mid();
    bus.req1 = 1'b1; bus.op1 = 1'b1; bus.addr1 = 3'd2; bus.wdata1 = 8'h5A;
    tick();
    n_cmp++;
    if ({bus.gnt1, bus.mem_select} !== 2'b11) begin
      n_fail++; $display("FAIL rm_issue: got g1=%b sel=%b want 11", bus.gnt1, bus.mem_select);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 26'd0) begin
      n_fail++; $display("FAIL rm_async: got %h want %h", outs, 26'd0);
    end
    tick();
    bus.req0 = 1'b1; bus.op0 = 1'b0; bus.addr0 = 3'd0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b1000) begin
      n_fail++; $display("FAIL rm_first: got g0=%b g1=%b d0=%b d1=%b want 1000",
        bus.gnt0, bus.gnt1, bus.done0, bus.done1);
    end
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.req0 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.gnt1, bus.mem_rw, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 3'd2, 8'h5A}) begin
      n_fail++; $display("FAIL rm_second: got g1=%b rw=%b a=%0d d=%h",
        bus.gnt1, bus.mem_rw, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    bus.req0 = 1'b1; bus.op0 = 1'b0; bus.addr0 = 3'd2;
    tick();
    bus.addr0 = 3'd7;
    tick();
    n_cmp++;
    if (bus.mem_addr !== 3'd2) begin
      n_fail++; $display("FAIL ac_hold1: got %0d want 2", bus.mem_addr);
    end
    tick();
    n_cmp++;
    if (bus.mem_addr !== 3'd2) begin
      n_fail++; $display("FAIL ac_hold2: got %0d want 2", bus.mem_addr);
    end
    bus.mem_rdata = 8'hC3; bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0; bus.req0 = 1'b0;
    n_cmp++;
    if ({bus.done0, bus.mem_addr, bus.rdata} !== {1'b1, 3'd2, 8'hC3}) begin
      n_fail++; $display("FAIL ac_done: got d0=%b a=%0d rdata=%h want 1 2 c3",
        bus.done0, bus.mem_addr, bus.rdata);
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_addr_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
